// File: rtl/ahb_slave_mem.sv
// Zero-wait-state AHB-Lite memory slave: one word per haddr index, pipelined
// address/data phases, one transfer per cycle.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    output logic                  hready,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  valid_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  active_tr;
    logic                  wr_en;
    logic                  rd_en;

    assign active_tr = (htrans == TR_NONSEQ) || (htrans == TR_SEQ);
    assign wr_en     = valid_q && write_q;
    assign rd_en     = valid_q && !write_q;

    // hresetn is active-high here: 1 holds the slave in reset.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            hready  <= 1'b0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            hready  <= 1'b1;
            valid_q <= hready && active_tr;
            if (hready && active_tr) begin
                write_q <= hwrite;
                addr_q  <= haddr;
            end
        end
    end

    // Storage has no reset; a data phase interrupted by reset is dropped.
    always_ff @(posedge hclk) begin
        if (!hresetn && wr_en) begin
            mem[addr_q] <= hwdata;
        end
    end

    always_comb begin
        hrdata = '0;
        if (rd_en) begin
            hrdata = mem[addr_q];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: reset, writes, reads, pipelining, reset abort.
module tb_ahb_slave_mem;

    logic        hclk;
    logic        hresetn;
    logic        hready;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [7:0]  haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;

    int passed = 0;
    int total  = 0;

    ahb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) uut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .hready  (hready),
        .htrans  (htrans),
        .hwrite  (hwrite),
        .haddr   (haddr),
        .hwdata  (hwdata),
        .hrdata  (hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_xfer(input logic [7:0] a, input logic [31:0] d);
        htrans = 2'd2; hwrite = 1'b1; haddr = a;
        step();
        htrans = 2'd0; hwrite = 1'b0; hwdata = d;
        step();
        hwdata = 32'h0;
    endtask

    task automatic read_addr(input logic [7:0] a);
        htrans = 2'd2; hwrite = 1'b0; haddr = a;
        step();
        htrans = 2'd0;
    endtask

    initial begin
        hresetn = 1'b1; htrans = 2'd0; hwrite = 1'b0; haddr = 8'h0; hwdata = 32'h0;
        repeat (5) step();
        hresetn = 1'b0;
        check("rst_hready", {31'b0, hready}, 32'h0);
        check("rst_hrdata", hrdata, 32'h0);

        // IDLE presented while hready is still low
        hwdata = 32'hDEADBEEF;
        step();
        check("idle_hready", {31'b0, hready}, 32'h1);
        check("idle_hrdata", hrdata, 32'h0);
        hwdata = 32'h0;

        write_xfer(8'h0D, 32'h5A5A5A5A);
        check("wr_0d", uut.mem[8'h0D], 32'h5A5A5A5A);
        write_xfer(8'h00, 32'h0);
        check("wr_00", uut.mem[8'h00], 32'h0);
        write_xfer(8'h0C, 32'h0);
        check("wr_0c", uut.mem[8'h0C], 32'h0);

        // BUSY write-looking transfer must not touch memory
        htrans = 2'd1; hwrite = 1'b1; haddr = 8'h0D;
        step();
        htrans = 2'd0; hwrite = 1'b0; hwdata = 32'h00000BAD;
        step();
        check("busy_nowr", uut.mem[8'h0D], 32'h5A5A5A5A);
        check("busy_hready", {31'b0, hready}, 32'h1);
        hwdata = 32'h0;

        // back-to-back NONSEQ writes, one per cycle
        for (int i = 0; i <= 10; i++) begin
            htrans = 2'd2; hwrite = 1'b1; haddr = 8'(8'h99 - i);
            if (i > 0) hwdata = 32'(32'hFFF - (i - 1));
            step();
            if (i > 0) check($sformatf("b2b_%0d", i - 1), uut.mem[8'(8'h99 - (i - 1))], 32'(32'hFFF - (i - 1)));
        end
        htrans = 2'd0; hwrite = 1'b0; hwdata = 32'hFFF - 32'd10;
        step();
        check("b2b_10", uut.mem[8'h8F], 32'hFF5);
        check("b2b_first_kept", uut.mem[8'h99], 32'hFFF);
        hwdata = 32'h0;

        // reads with backdoor preload
        uut.mem[8'h0C] = 32'h0;
        read_addr(8'h0C);
        check("rd_0c", hrdata, 32'h0);
        check("rd_0c_hready", {31'b0, hready}, 32'h1);
        step();
        uut.mem[8'h10] = 32'h12345678;
        read_addr(8'h10);
        check("rd_10", hrdata, 32'h12345678);
        step();
        check("rd_after_idle", hrdata, 32'h0);
        read_addr(8'h0D);
        check("rd_0d", hrdata, 32'h5A5A5A5A);
        step();

        // write immediately followed by read of the same word
        htrans = 2'd2; hwrite = 1'b1; haddr = 8'h02;
        step();
        hwdata = 32'h22; htrans = 2'd2; hwrite = 1'b0; haddr = 8'h02;
        step();
        htrans = 2'd0; hwdata = 32'h0;
        check("wr_rd_fwd", hrdata, 32'h22);
        step();

        // reset asserted during a write's data phase
        uut.mem[8'h05] = 32'h11;
        htrans = 2'd2; hwrite = 1'b1; haddr = 8'h05;
        step();
        htrans = 2'd0; hwrite = 1'b0; hwdata = 32'hDEAD; hresetn = 1'b1;
        step();
        check("rst_abort_mem", uut.mem[8'h05], 32'h11);
        check("rst_abort_hready", {31'b0, hready}, 32'h0);
        hresetn = 1'b0;
        step();
        check("rst_abort_mem2", uut.mem[8'h05], 32'h11);
        check("rst_rel_hready", {31'b0, hready}, 32'h1);
        write_xfer(8'h05, 32'h77);
        check("post_rst_wr", uut.mem[8'h05], 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
